// File: rtl/ram_rd_mux_pipe.sv
// Registered N:1 bank read-word selector with a programmable, range-checked select register,
// a single-entry valid/ready output stage and a wrapping transfer counter.
module ram_rd_mux_pipe #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 16,
   parameter int SEL_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    sel_load,
   output logic [WIDTH-1:0]        out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err,
   output logic [CNT_W-1:0]        xfer_cnt
);

   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_eff;
   logic             sel_ok;
   logic             capture;
   logic [WIDTH-1:0] word;

   assign sel_ok   = (32'(sel) < NUM_IN);
   // A valid load steers a capture in the same cycle; a rejected one falls back to sel_q.
   assign sel_eff  = (sel_load && sel_ok) ? sel : sel_q;
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready;

   // NOTE: default assigned first so every path drives word and no latch is inferred.
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel_eff == SEL_W'(k)) word = in[k*WIDTH +: WIDTH];
      end
   end

   // NOTE: non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         sel_err <= 1'b0;
      end else if (sel_load) begin
         if (sel_ok) begin
            sel_q   <= sel;
            sel_err <= 1'b0;
         end else begin
            sel_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         xfer_cnt  <= '0;
      end else if (capture) begin
         out       <= word;
         out_valid <= 1'b1;
         xfer_cnt  <= xfer_cnt + CNT_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_rd_mux_pipe.sv
// Randomized scoreboard bench for ram_rd_mux_pipe: a transaction-level model predicts
// accepted words, select state and counter; a monitor checks each consumed output word.
module tb_ram_rd_mux_pipe;
   localparam int WIDTH  = 8;
   localparam int NUM_IN = 12;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 4;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] din;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        sel;
   logic                    sel_load;
   logic [WIDTH-1:0]        out;
   logic                    out_valid;
   logic                    out_ready;
   logic                    sel_err;
   logic [CNT_W-1:0]        xfer_cnt;

   ram_rd_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .sel_load(sel_load), .out(out), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: words expected downstream, select register, error flag, capture count.
   int unsigned exp_q[$];
   int          m_sel;
   bit          m_err;
   int          m_cnt;
   bit          m_full;
   bit          last_blocked;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bank(input int k);
      return int'(din[k*WIDTH +: WIDTH]);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_sel  = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_full = 1'b0;
      last_blocked = 1'b0;
   endtask

   // One clock cycle with the inputs currently driven; checks flow control and state.
   task automatic step();
      int  eff;
      bit  exp_rdy;
      bit  accept;
      @(negedge clk);
      exp_rdy = !m_full || out_ready;
      check("in_ready", int'(in_ready), int'(exp_rdy));
      check("sel_err", int'(sel_err), int'(m_err));
      check("xfer_cnt", int'(xfer_cnt), m_cnt);
      eff    = (sel_load && int'(sel) < NUM_IN) ? int'(sel) : m_sel;
      accept = in_valid && exp_rdy;
      if (accept) begin
         exp_q.push_back(bank(eff));
         m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      m_full = accept || (m_full && !out_ready);
      last_blocked = in_valid && !exp_rdy;
      if (sel_load) begin
         if (int'(sel) < NUM_IN) begin
            m_sel = int'(sel);
            m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every word the DUT hands over must match the oldest predicted word.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_extra: got %0h expected no word at %0t", out, $time);
         end else begin
            check("out_word", int'(out), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sel_load  = 1'b0;
      sel       = '0;
      for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = 8'(8'hA0 + k);
      model_reset();

      // Reset held for three cycles with in_valid high.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", int'(out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_sel_err", int'(sel_err), 0);
      check("rst_xfer_cnt", int'(xfer_cnt), 0);
      check("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;

      // First capture after reset uses bank 0.
      step();
      check("first_bank0", int'(out), 8'hA0);

      // Select sweep with the load applied in the same cycle as the capture.
      for (int k = 0; k < NUM_IN; k++) begin
         sel_load = 1'b1;
         sel      = SEL_W'(k);
         step();
         check("sweep_out", int'(out), 8'hA0 + k);
      end
      sel_load = 1'b0;
      in_valid = 1'b0;
      step();
      check("sweep_cnt", int'(xfer_cnt), (NUM_IN + 1) % 16);

      // Out-of-range load is rejected and leaves the previous select in place.
      sel_load = 1'b1; sel = 4'd5;  step();
      sel = 4'd14; step();
      sel_load = 1'b0;
      check("oor_err_set", int'(sel_err), 1);
      in_valid = 1'b1; step();
      check("oor_keeps_bank5", int'(out), 8'hA5);
      in_valid = 1'b0;
      sel_load = 1'b1; sel = 4'd3; step();
      sel_load = 1'b0;
      check("oor_err_clear", int'(sel_err), 0);

      // Backpressure: captured word holds while the sink stalls.
      din[2*WIDTH +: WIDTH] = 8'h11;
      sel_load = 1'b1; sel = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
      step();
      sel_load = 1'b0;
      din[2*WIDTH +: WIDTH] = 8'h22;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stall_out_hold", int'(out), 8'h11);
      end
      out_ready = 1'b1;
      step();
      check("stall_release_out", int'(out), 8'h22);
      for (int i = 0; i < 4; i++) begin
         din[2*WIDTH +: WIDTH] = 8'(8'h30 + i);
         step();
         check("stream_out", int'(out), 8'h30 + i);
      end

      // Asynchronous reset between edges while a word is pending.
      out_ready = 1'b0;
      step();
      check("pre_async_valid", int'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", int'(out_valid), 0);
      check("async_xfer_cnt", int'(xfer_cnt), 0);
      check("async_in_ready", int'(in_ready), 1);
      model_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      step();
      check("post_reset_idle", int'(out_valid), 0);

      // Counter wraps modulo 2**CNT_W.
      in_valid = 1'b1;
      repeat (17) step();
      check("cnt_wrap", int'(xfer_cnt), 1);

      // Randomized traffic with upstream holding its word during stalls.
      for (int i = 0; i < 400; i++) begin
         if (!last_blocked) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         sel_load  = ($urandom_range(0, 4) == 0);
         sel       = 4'($urandom_range(0, 15));
         step();
      end

      // Drain and confirm every predicted word was delivered.
      in_valid  = 1'b0;
      sel_load  = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      check("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
